// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits byte/half/word loads and stores onto an
// 8-bit single-port RAM bus (little-endian) and pulses rdy on completion.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [1:0]            op,
  input  logic [1:0]            len,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_in,
  output logic                  rdy,
  output logic [31:0]           data_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  restart_q, restart_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rdy_q, rdy_d;
  logic [31:0]           data_out_q, data_out_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic                  mem_wr_q, mem_wr_d;

  logic [2:0]            len_bytes;
  logic [2:0]            cnt_inc;
  logic [1:0]            cap_idx;
  logic [ADDR_WIDTH-1:0] step_addr;

  always_comb begin
    case (len)
      2'b00:   len_bytes = 3'd1;
      2'b01:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  end

  assign cnt_inc   = cnt_q + 3'd1;
  assign cap_idx   = cnt_q[1:0] - 2'd1;
  assign step_addr = addr_q + ADDR_WIDTH'(cnt_inc);

  always_comb begin
    state_d    = state_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    restart_d  = restart_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdy_d      = rdy_q;
    data_out_d = data_out_q;
    mem_dout_d = mem_dout_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = mem_wr_q;

    if (rdy_in) begin
      case (state_q)
        StIdle: begin
          if (op == OpLoad || op == OpStore) begin
            addr_d     = addr;
            wdata_d    = data_in;
            nbytes_d   = len_bytes;
            cnt_d      = 3'd0;
            restart_d  = 1'b0;
            mem_a_d    = addr;
            data_out_d = 32'h0;
            if (op == OpLoad) begin
              state_d = StLoad;
            end else begin
              state_d    = StStore;
              mem_wr_d   = 1'b1;
              mem_dout_d = data_in[7:0];
            end
          end
        end
        StLoad: begin
          // A paused load behaves as if freshly accepted at the resume edge.
          if (restart_q) begin
            restart_d = 1'b0;
            cnt_d     = 3'd0;
            mem_a_d   = addr_q;
          end else begin
            // cnt counts edges since issue; byte cnt-1 arrives one cycle after its address.
            if (cnt_q != 3'd0) begin
              data_out_d = data_out_q | (32'(mem_din) << {cap_idx, 3'b000});
            end
            if (cnt_q == nbytes_q) begin
              rdy_d   = 1'b1;
              state_d = StDone;
            end else begin
              cnt_d = cnt_inc;
            end
            if (cnt_inc < nbytes_q) begin
              mem_a_d = step_addr;
            end
          end
        end
        StStore: begin
          if (cnt_inc == nbytes_q) begin
            mem_wr_d = 1'b0;
            rdy_d    = 1'b1;
            state_d  = StDone;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = step_addr;
            mem_dout_d = 8'(wdata_q >> {cnt_inc[1:0], 3'b000});
          end
        end
        StDone: begin
          rdy_d   = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StLoad) begin
      cnt_d      = 3'd0;
      restart_d  = 1'b1;
      data_out_d = 32'h0;
      mem_a_d    = addr_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      nbytes_q   <= 3'd0;
      cnt_q      <= 3'd0;
      restart_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rdy_q      <= 1'b0;
      data_out_q <= 32'h0;
      mem_dout_q <= 8'h0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      nbytes_q   <= nbytes_d;
      cnt_q      <= cnt_d;
      restart_q  <= restart_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdy_q      <= rdy_d;
      data_out_q <= data_out_d;
      mem_dout_q <= mem_dout_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign rdy      = rdy_q;
  assign data_out = data_out_q;
  assign mem_dout = mem_dout_q;
  assign mem_a    = mem_a_q;
  // A paused chip must never write, even with a store byte pending.
  assign mem_wr   = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural RAM, a request-level reference model with
// write/completion queues, and a per-cycle compare process.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [1:0]  op = 2'b00;
  logic [1:0]  len = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic        rdy;
  logic [31:0] data_out;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .op       (op),
    .len      (len),
    .addr     (addr),
    .data_in  (data_in),
    .rdy      (rdy),
    .data_out (data_out),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr)
  );

  // Initial RAM image, indexed by the low 16 address bits.
  function automatic logic [7:0] image(input int idx);
    case (idx)
      'h0100: return 8'h13;
      'h0101: return 8'h05;
      'h0102: return 8'h10;
      'h0000: return 8'h12;
      'h0001: return 8'hC3;
      'h0002: return 8'hB2;
      'h0003: return 8'hA1;
      'h0004: return 8'h88;
      'h0005: return 8'h77;
      'h0006: return 8'h66;
      'h0007: return 8'h55;
      'h0008: return 8'hCC;
      'h0009: return 8'hBB;
      'h000A: return 8'hAA;
      'h000B: return 8'h99;
      'hFFFF: return 8'h34;
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  logic [7:0] ram [65536];
  logic [7:0] rd_q;
  assign mem_din = rd_q;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = image(i);
    forever begin
      @(posedge clk_in);
      if (mem_wr) ram[mem_a[15:0]] = mem_dout;
      rd_q <= ram[mem_a[15:0]];
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [65536];
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic ld; logic [31:0] d;} cpl_t;
  wr_t  exp_wr[$];
  cpl_t exp_cpl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] l);
    return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_req(input logic [1:0] o, input logic [1:0] l, input logic [31:0] a,
                           input logic [31:0] d);
    cpl_t c;
    logic [31:0] ba;
    c.ld = (o == 2'b01);
    c.d  = 32'h0;
    for (int i = 0; i < nbytes(l); i++) begin
      ba = a + 32'(i);
      if (c.ld) begin
        c.d = c.d | (32'(ref_mem[ba[15:0]]) << (8 * i));
      end else begin
        exp_wr.push_back('{a: ba, d: d[8*i +: 8]});
        ref_mem[ba[15:0]] = d[8*i +: 8];
      end
    end
    exp_cpl.push_back(c);
  endtask

  // Per-cycle compare against the model queues.
  logic prev_pulse = 1'b0;
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (!rdy_in) chk("wr_gated_when_paused", 32'(mem_wr), 32'h0);
      if (mem_wr) begin
        chk("write_expected", 32'(exp_wr.size() != 0), 32'h1);
        if (exp_wr.size() != 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write_addr", mem_a, w.a);
          chk("write_data", 32'(mem_dout), 32'(w.d));
        end
      end
      if (prev_pulse) chk("rdy_single_pulse", 32'(rdy), 32'h0);
      if (rdy && rdy_in) begin
        chk("completion_expected", 32'(exp_cpl.size() != 0), 32'h1);
        if (exp_cpl.size() != 0) begin
          cpl_t c;
          c = exp_cpl.pop_front();
          if (c.ld) chk("load_data", data_out, c.d);
        end
      end
      prev_pulse <= rdy && rdy_in;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  // Issue one request (called #1 after a posedge) and wait for its rdy.
  // Request inputs are scrambled after acceptance to prove they were latched.
  task automatic txn(input logic [1:0] o, input logic [1:0] l, input logic [31:0] a,
                     input logic [31:0] d, input int pause_at, input int exp_cyc,
                     output logic [31:0] got);
    int cyc;
    model_req(o, l, a, d);
    op = o; len = l; addr = a; data_in = d;
    @(posedge clk_in);
    #1;
    op = 2'b00; len = ~l; addr = ~a; data_in = ~d;
    cyc = 0;
    got = 32'hx;
    while (cyc < 40) begin
      @(negedge clk_in);
      if (rdy) begin
        got = data_out;
        break;
      end
      @(posedge clk_in);
      cyc++;
      #1;
      if (pause_at > 0 && cyc == pause_at) rdy_in = 1'b0;
      if (pause_at > 0 && cyc == pause_at + 3) rdy_in = 1'b1;
    end
    chk("latency", cyc, exp_cyc);
    @(posedge clk_in);
    #1;
  endtask

  logic [31:0] got;
  int          diffs;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = image(i);
    rst_in = 1'b1;
    rdy_in = 1'b1;
    #1 rst_in = 1'b0;
    #2;
    chk("reset_rdy", 32'(rdy), 32'h0);
    chk("reset_mem_wr", 32'(mem_wr), 32'h0);
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_mem_a", mem_a, 32'h0);
    chk("reset_mem_dout", 32'(mem_dout), 32'h0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    txn(2'b01, 2'b10, 32'h0000_0100, 32'h0, 0, 5, got);
    chk("word_load_0x100", got, 32'h0010_0513);
    txn(2'b10, 2'b00, 32'h0000_2000, 32'hAABB_CCDD, 0, 1, got);
    txn(2'b01, 2'b00, 32'h0000_2000, 32'h0, 0, 2, got);
    chk("byte_load_0x2000", got, 32'h0000_00DD);
    txn(2'b01, 2'b01, 32'hFFFF_FFFF, 32'h0, 0, 3, got);
    chk("half_load_wrap", got, 32'h0000_1234);
    txn(2'b10, 2'b01, 32'h0000_2002, 32'h0000_5A6B, 0, 2, got);
    txn(2'b01, 2'b11, 32'h0000_2000, 32'h0, 0, 5, got);
    chk("len3_as_word", got, 32'h5A6B_00DD);

    // op=2'b11 is a NOP: nothing may happen.
    op = 2'b11; len = 2'b10; addr = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("nop3_no_rdy", 32'(rdy), 32'h0);
      chk("nop3_no_wr", 32'(mem_wr), 32'h0);
    end
    @(posedge clk_in);
    #1 op = 2'b00;

    // Fetch-style requester: LOAD held, pc advanced after each rdy.
    begin
      logic [31:0] fetched [3];
      int cyc, last, f;
      logic [31:0] pc;
      pc = 32'h0;
      model_req(2'b01, 2'b10, pc, 32'h0);
      op = 2'b01; len = 2'b10; addr = pc;
      cyc = 0; last = 0; f = 0;
      while (f < 3 && cyc < 100) begin
        @(negedge clk_in);
        if (rdy) begin
          fetched[f] = data_out;
          if (f > 0) chk("fetch_gap", cyc - last, 7);
          last = cyc;
          @(posedge clk_in);
          cyc++;
          #1;
          f++;
          if (f < 3) begin
            pc = pc + 32'd4;
            addr = pc;
            model_req(2'b01, 2'b10, pc, 32'h0);
          end else begin
            op = 2'b00;
          end
        end else begin
          @(posedge clk_in);
          cyc++;
        end
      end
      chk("fetch_count", f, 3);
      chk("fetch0", fetched[0], 32'hA1B2_C312);
      chk("fetch1", fetched[1], 32'h5566_7788);
      chk("fetch2", fetched[2], 32'h99AA_BBCC);
    end

    // Pauses mid word load and mid word store.
    txn(2'b01, 2'b10, 32'h0000_0100, 32'h0, 3, 12, got);
    chk("paused_load", got, 32'h0010_0513);
    txn(2'b10, 2'b10, 32'h0000_3000, 32'hCAFE_F00D, 2, 7, got);
    txn(2'b01, 2'b10, 32'h0000_3000, 32'h0, 0, 5, got);
    chk("paused_store_readback", got, 32'hCAFE_F00D);

    // Asynchronous reset after two bytes of a word store.
    exp_wr.push_back('{a: 32'h0000_4000, d: 8'hEF});
    exp_wr.push_back('{a: 32'h0000_4001, d: 8'hBE});
    ref_mem[16'h4000] = 8'hEF;
    ref_mem[16'h4001] = 8'hBE;
    op = 2'b10; len = 2'b10; addr = 32'h0000_4000; data_in = 32'hDEAD_BEEF;
    @(posedge clk_in);
    #1 op = 2'b00;
    repeat (2) @(posedge clk_in);
    #3 rst_in = 1'b0;
    #1;
    chk("rst_mid_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mid_rdy", 32'(rdy), 32'h0);
    chk("rst_mid_mem_a", mem_a, 32'h0);
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    txn(2'b01, 2'b10, 32'h0000_4000, 32'h0, 0, 5, got);
    chk("load_after_reset", got, 32'h0000_BEEF);

    repeat (3) @(posedge clk_in);
    chk("writes_drained", exp_wr.size(), 0);
    chk("completions_drained", exp_cpl.size(), 0);
    chk("neighbour_below", 32'(ram[16'h1FFF]), 32'h0);
    chk("store_byte_0x2000", 32'(ram[16'h2000]), 32'hDD);
    chk("neighbour_above", 32'(ram[16'h2001]), 32'h0);
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) diffs++;
    chk("ram_vs_model", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of the fetch stage. Serves that stage's request port: op/len/addr in, rdy/data out.
- Serialises each byte/half/word load or store onto the 8-bit, single-port RAM bus, little-endian.
- Assembles load bytes into a 32-bit result and signals completion with a one-cycle ready pulse.
- The same port also serves later load/store traffic; arbitration between requesters is outside this block.

Parameters:
- ADDR_WIDTH, 32, width of request and RAM addresses; byte address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clk_in  input  1  clock; all state changes on its rising edge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global chip-ready; low pauses the block
- op  input  2  request opcode: 2'b00 NOP, 2'b01 LOAD, 2'b10 STORE, 2'b11 treated as NOP
- len  input  2  access size: 2'b00 BYTE, 2'b01 HALF, 2'b10 WORD, 2'b11 treated as WORD
- addr  input  ADDR_WIDTH  byte address of the access
- data_in  input  32  store data; low len bytes are used, LSB first
- rdy  output  1  one-cycle completion pulse
- data_out  output  32  load result, zero-extended; valid while rdy=1
- mem_din  input  8  RAM read data
- mem_dout  output  8  RAM write data
- mem_a  output  ADDR_WIDTH  RAM address
- mem_wr  output  1  RAM write enable, 1 = write

Behaviour:
- Reset (rst_in=0, async):
  - State goes to IDLE immediately.
  - All of rdy, data_out, mem_a, mem_dout and mem_wr go to 0 immediately, including mid-transaction.
  - No partial store continues.
- N = 1/2/4 bytes for BYTE/HALF/WORD. Byte i addresses addr+i, modulo 2^ADDR_WIDTH.
- States: IDLE, LOAD, STORE, DONE.
- IDLE:
  - Accepts when op is LOAD or STORE at an edge with rdy_in=1 (acceptance edge k).
  - At k, latches op, len, addr and data_in; later changes on the request inputs are ignored until rdy.
  - Loads mem_a=addr and cnt=0.
  - For STORE, also drives mem_wr=1 and mem_dout=data_in[7:0].
- RAM read latency is one cycle. mem_din during the cycle after the edge where the RAM sampled mem_a holds that byte.
- LOAD:
  - mem_a steps addr, addr+1, … on edges k, k+1, …
  - Byte i is captured into data_out[8i+7:8i] at edge k+2+i.
  - Unused upper bytes of data_out are 0.
  - The final capture edge k+N+1 also sets rdy=1 and enters DONE.
  - Word load: rdy is high in the cycle after edge k+5.
  - mem_wr stays 0 throughout.
- STORE:
  - Byte i (mem_a=addr+i, mem_dout=data_in[8i+7:8i], mem_wr=1) is driven from edge k+i.
  - At edge k+N: mem_wr goes to 0, rdy goes to 1, state enters DONE.
  - Exactly N writes occur, each address written once.
- DONE:
  - Lasts one cycle; next edge clears rdy and returns to IDLE.
  - A request present at that edge is not accepted. It is accepted at the following edge.
  - Consequence: a requester holding LOAD continuously (fetch-style) gets back-to-back transactions with a one-cycle gap and no duplicates.
- rdy_in=0:
  - FSM, counters and registered outputs hold; mem_wr is gated combinationally to 0.
  - An in-flight LOAD additionally resets cnt to 0, clears data_out and reloads mem_a=addr. After resume it restarts the access from byte 0, with the same timing as a fresh acceptance at the resume edge.
  - An in-flight STORE resumes with the pending byte; that byte is written once after resume.
  - rdy_in=0 during DONE holds rdy high until rdy_in returns. The requester must qualify rdy with rdy_in.
- Simultaneous rst_in=0 and any other event: reset wins.
- NOP or rdy_in=0 in IDLE: no RAM activity; mem_a holds its last value.

Test Plan:
- Word LOAD at addr 0x100 with RAM bytes 13 05 10 00 -> data_out=0x00100513. rdy is a single-cycle pulse after edge k+5; mem_wr=0 throughout.
- STORE BYTE at 0x2000 with data_in=0xAABBCCDD -> exactly one write of 0xDD to 0x2000. rdy after edge k+1; neighbouring bytes unchanged.
- HALF LOAD at 0xFFFFFFFF with bytes 0x34 at 0xFFFFFFFF and 0x12 at 0x0 -> data_out=0x00001234. mem_a wraps to 0.
- Fetch-style requester holding LOAD with pc 0x0, 0x4, 0x8 advanced on each rdy -> three correct words, one idle cycle between them, no repeated or skipped fetch.
- rdy_in low for 3 cycles after byte 1 of a word LOAD -> load restarts from addr and returns the correct word. Same pause mid word STORE to 0x3000 -> mem_wr=0 during the pause; 0x3000–0x3003 each written once with correct data.
- rst_in=0 asynchronously mid word STORE after 2 bytes -> mem_wr and rdy drop without a clock edge. After release: IDLE, no further writes, a new LOAD completes normally.
